// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence transmitter and the 010 detector.
package seq_pkg;

    localparam int   REP_W          = 4;
    localparam logic IDLE_LEVEL_DEF = 1'b1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SHIFT,
        TX_DONE
    } tx_state_t;

    typedef enum logic [1:0] {
        DET_S0,
        DET_S1,
        DET_S01
    } det_state_t;

endpackage

// File: rtl/tx_bit_counter.sv
// Bit-within-pattern and repetition counters for the serial pattern transmitter.
module tx_bit_counter
    import seq_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [LEN_W-1:0] len,
    input  logic [REP_W-1:0] rep,
    output logic [LEN_W-1:0] bitcnt,
    output logic [REP_W-1:0] repcnt,
    output logic             last_bit,
    output logic             last_rep
);

    // Terminal compares use the captured length and repeat count, so neither counter wraps.
    assign last_bit = (bitcnt == (len - LEN_W'(1)));
    assign last_rep = (repcnt == rep);

    // Bit counter restarts at the end of each pattern; repetition counter advances there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bitcnt <= '0;
            repcnt <= '0;
        end else if (clr) begin
            bitcnt <= '0;
            repcnt <= '0;
        end else if (en) begin
            if (last_bit) begin
                bitcnt <= '0;
                if (!last_rep) begin
                    repcnt <= repcnt + REP_W'(1);
                end
            end else begin
                bitcnt <= bitcnt + LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: accepts a pattern over valid/ready and shifts it
// out MSB-first, optionally repeated back-to-back, with registered outputs.
module serial_pattern_tx
    import seq_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [$clog2(WIDTH+1)-1:0] in_len,
    input  logic [REP_W-1:0]           in_rep,
    output logic                       ser_out,
    output logic                       ser_valid,
    output logic                       busy,
    output logic                       done
);

    localparam int LEN_W = $clog2(WIDTH+1);

    tx_state_t        state;
    tx_state_t        next_state;
    logic [WIDTH-1:0] data_q;
    logic [LEN_W-1:0] len_q;
    logic [REP_W-1:0] rep_q;
    logic [LEN_W-1:0] bitcnt;
    logic [REP_W-1:0] repcnt;
    logic             last_bit;
    logic             last_rep;
    logic             accept;
    logic             cnt_clr;
    logic             cnt_en;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        if (l > LEN_W'(WIDTH)) begin
            return LEN_W'(WIDTH);
        end
        return l;
    endfunction

    // Selects data[len-1-cnt]; only called while shifting, where len >= 1 and cnt < len.
    function automatic logic pattern_bit(input logic [WIDTH-1:0] d,
                                         input logic [LEN_W-1:0] l,
                                         input logic [LEN_W-1:0] cnt);
        logic [LEN_W-1:0] idx;
        logic             b;
        idx = l - LEN_W'(1) - cnt;
        b   = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (LEN_W'(i) == idx) begin
                b = d[i];
            end
        end
        return b;
    endfunction

    tx_bit_counter #(
        .LEN_W (LEN_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .len      (len_q),
        .rep      (rep_q),
        .bitcnt   (bitcnt),
        .repcnt   (repcnt),
        .last_bit (last_bit),
        .last_rep (last_rep)
    );

    // Next-state and counter control.
    always_comb begin
        next_state = state;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        accept     = in_valid && in_ready;
        case (state)
            TX_IDLE: begin
                if (accept) begin
                    cnt_clr    = 1'b1;
                    next_state = (clamp_len(in_len) != '0) ? TX_SHIFT : TX_DONE;
                end
            end
            TX_SHIFT: begin
                cnt_en = 1'b1;
                if (last_bit && last_rep) begin
                    next_state = TX_DONE;
                end
            end
            TX_DONE: begin
                next_state = TX_IDLE;
            end
            default: begin
                next_state = TX_IDLE;
            end
        endcase
    end

    // Request capture; these registers only change on an accepted handshake.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_q <= in_data;
            len_q  <= clamp_len(in_len);
            rep_q  <= in_rep;
        end
    end

    // State register and output registers; serial outputs lag the state by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= TX_IDLE;
            ser_out   <= IDLE_LEVEL;
            ser_valid <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            state     <= next_state;
            ser_valid <= (state == TX_SHIFT);
            ser_out   <= (state == TX_SHIFT) ? pattern_bit(data_q, len_q, bitcnt) : IDLE_LEVEL;
            done      <= (state == TX_DONE);
            busy      <= (next_state != TX_IDLE);
            in_ready  <= (state == TX_IDLE) && (next_state == TX_IDLE);
        end
    end

endmodule
